// File: rtl/fila_escrita_pkg.sv
// Shared constants and types for the write-back queue.
package fila_escrita_pkg;

  localparam int unsigned RegIdxW         = 5;
  localparam int unsigned ProfundidadeDef = 4;
  localparam int unsigned LarguraDef      = 32;

  typedef logic [RegIdxW-1:0] reg_idx_t;

endpackage

// File: rtl/fila_escrita_if.sv
// Producer, register-file and forwarding signals of the write-back queue.
interface fila_escrita_if
  import fila_escrita_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = ProfundidadeDef,
  parameter int unsigned LARGURA      = LarguraDef
) ();

  localparam int unsigned CntW = $clog2(PROFUNDIDADE) + 1;

  logic               in_valido;
  reg_idx_t           in_rd;
  logic [LARGURA-1:0] in_dados;
  logic               in_pronto;
  logic               descarta;
  logic               rf_ocupado;
  logic               reg_write;
  reg_idx_t           rd;
  logic [LARGURA-1:0] dados;
  reg_idx_t           rn;
  reg_idx_t           rm;
  logic               fwd_um_valido;
  logic               fwd_dois_valido;
  logic [LARGURA-1:0] fwd_um_dado;
  logic [LARGURA-1:0] fwd_dois_dado;
  logic               vazio;
  logic               cheio;
  logic [CntW-1:0]    contagem;

  // The queue itself.
  modport slave (
    input  in_valido, in_rd, in_dados, descarta, rf_ocupado, rn, rm,
    output in_pronto, reg_write, rd, dados, fwd_um_valido, fwd_dois_valido,
    output fwd_um_dado, fwd_dois_dado, vazio, cheio, contagem
  );

  // The surrounding pipeline.
  modport master (
    output in_valido, in_rd, in_dados, descarta, rf_ocupado, rn, rm,
    input  in_pronto, reg_write, rd, dados, fwd_um_valido, fwd_dois_valido,
    input  fwd_um_dado, fwd_dois_dado, vazio, cheio, contagem
  );

endinterface

// File: rtl/fila_escrita_busca.sv
// Youngest-match search of a register index over the occupied queue slots.
module fila_escrita_busca
  import fila_escrita_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = ProfundidadeDef,
  parameter int unsigned LARGURA      = LarguraDef
) (
  input  reg_idx_t                        chave_i,
  input  logic [$clog2(PROFUNDIDADE)-1:0] cabeca_i,
  input  logic [$clog2(PROFUNDIDADE):0]   contagem_i,
  input  reg_idx_t                        mem_rd_i    [PROFUNDIDADE],
  input  logic [LARGURA-1:0]              mem_dados_i [PROFUNDIDADE],
  output logic                            valido_o,
  output logic [LARGURA-1:0]              dado_o
);

  localparam int unsigned PtrW = $clog2(PROFUNDIDADE);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest; a later hit overrides, leaving the youngest match.
  always_comb begin
    valido_o = 1'b0;
    dado_o   = '0;
    idx      = '0;
    for (int unsigned k = 0; k < PROFUNDIDADE; k++) begin
      idx = cabeca_i + PtrW'(k);
      if ((CntW'(k) < contagem_i) && (mem_rd_i[idx] == chave_i)) begin
        valido_o = 1'b1;
        dado_o   = mem_dados_i[idx];
      end
    end
  end

endmodule

// File: rtl/fila_escrita.sv
// Circular write-back queue in front of the register file, with forwarding
// of pending writes to the two read ports.
module fila_escrita
  import fila_escrita_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = ProfundidadeDef,
  parameter int unsigned LARGURA      = LarguraDef
) (
  input logic          clock,
  input logic          reset_n,
  fila_escrita_if.slave bus
);

  localparam int unsigned PtrW = $clog2(PROFUNDIDADE);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  reg_idx_t           mem_rd_q    [PROFUNDIDADE];
  logic [LARGURA-1:0] mem_dados_q [PROFUNDIDADE];

  logic               vazio, cheio, aceita, retira;
  logic               fwd_um_valido, fwd_dois_valido;
  logic [LARGURA-1:0] fwd_um_dado, fwd_dois_dado;

  assign vazio  = (cnt_q == '0);
  assign cheio  = (cnt_q == CntW'(PROFUNDIDADE));
  // Acceptance looks only at the current fill level, never at a same-cycle drain.
  assign aceita = bus.in_valido && !cheio && !bus.descarta;
  assign retira = bus.reg_write && !bus.descarta;

  assign bus.in_pronto = !cheio;
  assign bus.vazio     = vazio;
  assign bus.cheio     = cheio;
  assign bus.contagem  = cnt_q;
  assign bus.reg_write = !vazio && !bus.rf_ocupado;
  // Hide unreset storage while empty.
  assign bus.rd        = vazio ? '0 : mem_rd_q[head_q];
  assign bus.dados     = vazio ? '0 : mem_dados_q[head_q];

  assign bus.fwd_um_valido   = fwd_um_valido;
  assign bus.fwd_um_dado     = fwd_um_dado;
  assign bus.fwd_dois_valido = fwd_dois_valido;
  assign bus.fwd_dois_dado   = fwd_dois_dado;

  // Next pointers and occupancy; a discard wins over accept and pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (bus.descarta) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (aceita) tail_d = tail_q + PtrW'(1);
      if (retira) head_d = head_q + PtrW'(1);
      unique case ({aceita, retira})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage, written at the tail on accept; not reset.
  always_ff @(posedge clock) begin
    if (aceita) begin
      mem_rd_q[tail_q]    <= bus.in_rd;
      mem_dados_q[tail_q] <= bus.in_dados;
    end
  end

  fila_escrita_busca #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARGURA)
  ) u_busca_rn (
    .chave_i     (bus.rn),
    .cabeca_i    (head_q),
    .contagem_i  (cnt_q),
    .mem_rd_i    (mem_rd_q),
    .mem_dados_i (mem_dados_q),
    .valido_o    (fwd_um_valido),
    .dado_o      (fwd_um_dado)
  );

  fila_escrita_busca #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARGURA)
  ) u_busca_rm (
    .chave_i     (bus.rm),
    .cabeca_i    (head_q),
    .contagem_i  (cnt_q),
    .mem_rd_i    (mem_rd_q),
    .mem_dados_i (mem_dados_q),
    .valido_o    (fwd_dois_valido),
    .dado_o      (fwd_dois_dado)
  );

endmodule

// File: tb/tb_fila_escrita.sv
// Bench for fila_escrita: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_fila_escrita;

  localparam int unsigned D = 4;
  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  fila_escrita_if #(.PROFUNDIDADE(D), .LARGURA(W)) bus ();

  fila_escrita #(.PROFUNDIDADE(D), .LARGURA(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: pending writes {rd, data}, oldest at index 0.
  logic [36:0] q [$];

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic desc, input logic ocup);
    bus.in_valido  = v;
    bus.in_rd      = r;
    bus.in_dados   = d;
    bus.descarta   = desc;
    bus.rf_ocupado = ocup;
  endtask

  task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
    bus.rn = a;
    bus.rm = b;
  endtask

  // One rising edge: update the reference from the inputs held across it.
  task automatic tick();
    bit can_acc;
    @(posedge clock);
    if (!reset_n || bus.descarta) begin
      q.delete();
    end else begin
      can_acc = (q.size() < D);
      if (q.size() > 0 && !bus.rf_ocupado) void'(q.pop_front());
      if (bus.in_valido && can_acc) q.push_back({bus.in_rd, bus.in_dados});
    end
    @(negedge clock);
  endtask

  function automatic logic [32:0] fwd_ref(input logic [4:0] key);
    for (int i = int'(q.size()) - 1; i >= 0; i--)
      if (q[i][36:32] == key) return {1'b1, q[i][31:0]};
    return 33'd0;
  endfunction

  task automatic pulse_reset();
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd9, 32'hDEAD, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    set_reads(5'd9, 5'd0);
    #1;
    checks++; if (bus.vazio !== 1'b1) begin failures++; $display("FAIL reset_vazio got=%b exp=1", bus.vazio); end
    checks++; if (bus.cheio !== 1'b0) begin failures++; $display("FAIL reset_cheio got=%b exp=0", bus.cheio); end
    checks++; if (bus.in_pronto !== 1'b1) begin failures++; $display("FAIL reset_in_pronto got=%b exp=1", bus.in_pronto); end
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", bus.reg_write); end
    checks++; if (bus.contagem !== 3'd0) begin failures++; $display("FAIL reset_contagem got=%0d exp=0", bus.contagem); end
    checks++; if (bus.fwd_um_valido !== 1'b0) begin failures++; $display("FAIL reset_fwd_um got=%b exp=0", bus.fwd_um_valido); end
  endtask

  task automatic test_push_forward();
    pulse_reset();
    set_reads(5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'h11, 1'b0, 1'b1);
    #1;
    checks++; if (bus.fwd_um_valido !== 1'b0) begin failures++; $display("FAIL pf_offer_not_fwd got=%b exp=0", bus.fwd_um_valido); end
    tick();
    drive(1'b1, 5'd7, 32'h22, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    set_reads(5'd7, 5'd3);
    #1;
    checks++; if (bus.contagem !== 3'd2) begin failures++; $display("FAIL pf_contagem got=%0d exp=2", bus.contagem); end
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL pf_reg_write got=%b exp=0", bus.reg_write); end
    checks++; if ({bus.fwd_um_valido, bus.fwd_um_dado} !== {1'b1, 32'h22}) begin failures++; $display("FAIL pf_fwd_um got=%b/%h exp=1/22", bus.fwd_um_valido, bus.fwd_um_dado); end
    checks++; if ({bus.fwd_dois_valido, bus.fwd_dois_dado} !== {1'b1, 32'h11}) begin failures++; $display("FAIL pf_fwd_dois got=%b/%h exp=1/11", bus.fwd_dois_valido, bus.fwd_dois_dado); end
  endtask

  task automatic test_same_rd();
    pulse_reset();
    set_reads(5'd0, 5'd0);
    drive(1'b1, 5'd5, 32'hA, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd5, 32'hB, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    set_reads(5'd1, 5'd5);
    #1;
    checks++; if ({bus.fwd_dois_valido, bus.fwd_dois_dado} !== {1'b1, 32'hB}) begin failures++; $display("FAIL same_fwd_dois got=%b/%h exp=1/b", bus.fwd_dois_valido, bus.fwd_dois_dado); end
    checks++; if ({bus.fwd_um_valido, bus.fwd_um_dado} !== 33'd0) begin failures++; $display("FAIL same_fwd_um_none got=%b/%h exp=0/0", bus.fwd_um_valido, bus.fwd_um_dado); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus.reg_write, bus.rd, bus.dados} !== {1'b1, 5'd5, 32'hA}) begin failures++; $display("FAIL same_first got=%b/%0d/%h exp=1/5/a", bus.reg_write, bus.rd, bus.dados); end
    tick();
    #1;
    checks++; if ({bus.reg_write, bus.rd, bus.dados} !== {1'b1, 5'd5, 32'hB}) begin failures++; $display("FAIL same_second got=%b/%0d/%h exp=1/5/b", bus.reg_write, bus.rd, bus.dados); end
    tick();
    #1;
    checks++; if ({bus.vazio, bus.reg_write} !== 2'b10) begin failures++; $display("FAIL same_empty got=%b%b exp=10", bus.vazio, bus.reg_write); end
  endtask

  task automatic test_full();
    logic [4:0]  rds  [4] = '{5'd30, 5'd31, 5'd30, 5'd2};
    logic [31:0] vals [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rds[i], vals[i], 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    set_reads(5'd30, 5'd31);
    #1;
    checks++; if ({bus.cheio, bus.in_pronto, bus.contagem} !== {1'b1, 1'b0, 3'd4}) begin failures++; $display("FAIL full_status got=%b/%b/%0d exp=1/0/4", bus.cheio, bus.in_pronto, bus.contagem); end
    checks++; if ({bus.fwd_um_valido, bus.fwd_um_dado} !== {1'b1, 32'h102}) begin failures++; $display("FAIL full_fwd_rd30 got=%b/%h exp=1/102", bus.fwd_um_valido, bus.fwd_um_dado); end
    checks++; if ({bus.fwd_dois_valido, bus.fwd_dois_dado} !== {1'b1, 32'h101}) begin failures++; $display("FAIL full_fwd_rd31 got=%b/%h exp=1/101", bus.fwd_dois_valido, bus.fwd_dois_dado); end
    tick();
    drive(1'b1, 5'd10, 32'h55, 1'b0, 1'b0);
    #1;
    checks++; if ({bus.in_pronto, bus.reg_write, bus.dados} !== {1'b0, 1'b1, 32'h100}) begin failures++; $display("FAIL full_drain_offer got=%b/%b/%h exp=0/1/100", bus.in_pronto, bus.reg_write, bus.dados); end
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      #1;
      if (i == 1) begin
        checks++; if (bus.contagem !== 3'd3) begin failures++; $display("FAIL full_after_reject got=%0d exp=3", bus.contagem); end
      end
      checks++; if ({bus.rd, bus.dados} !== {rds[i], vals[i]}) begin failures++; $display("FAIL full_order_%0d got=%0d/%h exp=%0d/%h", i, bus.rd, bus.dados, rds[i], vals[i]); end
      tick();
    end
    #1;
    checks++; if (bus.vazio !== 1'b1) begin failures++; $display("FAIL full_final_empty got=%b exp=1", bus.vazio); end
  endtask

  task automatic test_stream();
    logic [31:0] w [10];
    pulse_reset();
    for (int i = 0; i < 10; i++) w[i] = $urandom;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, 5'(20 + i), w[i], 1'b0, 1'b0);
      else drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      #1;
      if (i == 0) begin
        checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL stream_first_idle got=%b exp=0", bus.reg_write); end
      end else begin
        checks++; if ({bus.contagem, bus.reg_write, bus.rd, bus.dados} !== {3'd1, 1'b1, 5'(19 + i), w[i-1]}) begin
          failures++; $display("FAIL stream_%0d got=%0d/%b/%0d/%h exp=1/1/%0d/%h", i, bus.contagem, bus.reg_write, bus.rd, bus.dados, 19 + i, w[i-1]);
        end
      end
      tick();
    end
    #1;
    checks++; if (bus.vazio !== 1'b1) begin failures++; $display("FAIL stream_empty got=%b exp=1", bus.vazio); end
  endtask

  task automatic test_descarta();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(6 + i), 32'(16'h700 + i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    set_reads(5'd4, 5'd6);
    #1;
    checks++; if ({bus.reg_write, bus.dados} !== {1'b1, 32'h700}) begin failures++; $display("FAIL desc_reg_write got=%b/%h exp=1/700", bus.reg_write, bus.dados); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus.contagem, bus.vazio} !== {3'd0, 1'b1}) begin failures++; $display("FAIL desc_empty got=%0d/%b exp=0/1", bus.contagem, bus.vazio); end
    checks++; if ({bus.fwd_um_valido, bus.fwd_dois_valido, bus.fwd_dois_dado} !== 34'd0) begin failures++; $display("FAIL desc_fwd got=%b/%b/%h exp=0/0/0", bus.fwd_um_valido, bus.fwd_dois_valido, bus.fwd_dois_dado); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'(12 + i), 32'(16'hC00 + i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus.contagem, bus.reg_write, bus.in_pronto} !== {3'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL rstmid got=%0d/%b/%b exp=0/0/1", bus.contagem, bus.reg_write, bus.in_pronto); end
  endtask

  function automatic logic [4:0] pick_idx();
    int unsigned r = $urandom_range(0, 5);
    return (r < 4) ? 5'(r) : 5'(26 + r);
  endfunction

  task automatic test_random();
    int unsigned n;
    logic [32:0] f1, f2;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, pick_idx(), $urandom, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) == 0);
      set_reads(pick_idx(), pick_idx());
      reset_n = ($urandom_range(0, 59) != 0);
      #1;
      n  = q.size();
      f1 = fwd_ref(bus.rn);
      f2 = fwd_ref(bus.rm);
      checks++; if ({bus.in_pronto, bus.vazio, bus.cheio, bus.contagem} !== {n != D, n == 0, n == D, 3'(n)}) begin
        failures++; $display("FAIL rnd_status c=%0d got=%b/%b/%b/%0d exp_count=%0d", c, bus.in_pronto, bus.vazio, bus.cheio, bus.contagem, n);
      end
      checks++; if (bus.reg_write !== (n != 0 && !bus.rf_ocupado)) begin failures++; $display("FAIL rnd_reg_write c=%0d got=%b exp=%b", c, bus.reg_write, n != 0 && !bus.rf_ocupado); end
      if (n != 0) begin
        checks++; if ({bus.rd, bus.dados} !== q[0]) begin failures++; $display("FAIL rnd_head c=%0d got=%0d/%h exp=%0d/%h", c, bus.rd, bus.dados, q[0][36:32], q[0][31:0]); end
      end
      checks++; if ({bus.fwd_um_valido, bus.fwd_um_dado} !== f1) begin failures++; $display("FAIL rnd_fwd_um c=%0d got=%b/%h exp=%b/%h", c, bus.fwd_um_valido, bus.fwd_um_dado, f1[32], f1[31:0]); end
      checks++; if ({bus.fwd_dois_valido, bus.fwd_dois_dado} !== f2) begin failures++; $display("FAIL rnd_fwd_dois c=%0d got=%b/%h exp=%b/%h", c, bus.fwd_dois_valido, bus.fwd_dois_dado, f2[32], f2[31:0]); end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    set_reads(5'd0, 5'd0);
    @(negedge clock);
    test_reset();
    test_push_forward();
    test_same_rd();
    test_full();
    test_stream();
    test_descarta();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fila_escrita.md
FILA_ESCRITA -- requirements
Module: fila_escrita

Interface
REQ-001 SHALL have parameter PROFUNDIDADE, default 4, meaning number of pending-write entries (power of two, 2..16).
REQ-002 SHALL have parameter LARGURA, default 32, meaning data width of each register write.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port in_valido  input  1  meaning the producer offers a write this cycle.
REQ-006 SHALL have port in_rd  input  5  meaning the destination register index of the offered write.
REQ-007 SHALL have port in_dados  input  LARGURA  meaning the data of the offered write.
REQ-008 SHALL have port in_pronto  output  1  meaning the queue can accept a write this cycle.
REQ-009 SHALL have port descarta  input  1  meaning discard all pending entries.
REQ-010 SHALL have port rf_ocupado  input  1  meaning the register file write port is unavailable this cycle.
REQ-011 SHALL have ports reg_write  output  1, rd  output  5, dados  output  LARGURA  meaning the register-file write port drive.
REQ-012 SHALL have ports rn, rm  input  5 each  meaning the register indices currently being read.
REQ-013 SHALL have ports fwd_um_valido, fwd_dois_valido  output  1 each, fwd_um_dado, fwd_dois_dado  output  LARGURA each  meaning a pending write exists for rn/rm and its value.
REQ-014 SHALL have ports vazio, cheio  output  1 each, contagem  output  $clog2(PROFUNDIDADE)+1  meaning occupancy status.

Function
REQ-015 SHALL store entries {rd, dados} in a circular buffer with head/tail pointers that wrap from PROFUNDIDADE-1 to 0.
REQ-016 SHALL drive in_pronto = !cheio combinationally; no write acceptance when full, even if a drain occurs the same cycle.
REQ-017 SHALL accept an entry at the rising edge when in_valido && in_pronto && !descarta, storing it at the tail.
REQ-018 SHALL drive reg_write = !vazio && !rf_ocupado, with rd/dados equal to the head entry, combinationally (zero-cycle presentation).
REQ-019 SHALL pop the head at the rising edge whenever reg_write is 1 and descarta is 0.
REQ-020 SHALL keep contagem unchanged on a simultaneous accept and pop; increment on accept only; decrement on pop only.
REQ-021 SHALL drive vazio = (contagem == 0) and cheio = (contagem == PROFUNDIDADE).
REQ-022 SHALL, on descarta = 1, reset pointers and contagem to 0 at the next edge, ignoring any accept or pop that cycle; reg_write is still driven per REQ-018 during that cycle.
REQ-023 SHALL assert fwd_um_valido when any stored entry has rd == rn, with fwd_um_dado from the youngest matching entry; likewise fwd_dois_* for rm.
REQ-024 SHALL exclude the write being offered on in_* in the current cycle from forwarding; only stored entries are searched.
REQ-025 SHALL drive fwd_*_dado = 0 when the corresponding fwd_*_valido is 0.
REQ-026 SHALL treat rd indices 30 and 31 like any other index (no filtering of CPSR/link slots).
REQ-027 SHALL preserve FIFO order: writes reach the register file in acceptance order, including repeated writes to the same rd.

Reset
REQ-028 SHALL, while reset_n = 0 at a rising edge, clear head, tail and contagem to 0; vazio = 1, cheio = 0, in_pronto = 1, reg_write = 0 follow.
REQ-029 SHALL give reset priority over descarta, accept and pop; a reset mid-drain discards all entries.
REQ-030 SHALL not require entry storage to be reset; outputs SHALL not depend on unreset storage while vazio = 1.

Structure
REQ-031 SHALL place the register-index width (5), the default depth and default data width in a shared package with the core's other constants.
REQ-032 SHALL implement the youngest-match search as one sub-module, fila_escrita_busca, instantiated twice (rn, rm).

Verification
REQ-033 Reset, then push (rd=3, 0x11), (rd=7, 0x22) with rf_ocupado=1 -> contagem=2, reg_write=0, rn=7 gives fwd_um_valido=1, fwd_um_dado=0x22.
REQ-034 Push rd=5 with 0xA, then 0xB, rf_ocupado=1, rm=5 -> fwd_dois_dado=0xB; release rf_ocupado -> writes (5,0xA) then (5,0xB) on consecutive cycles, then vazio=1.
REQ-035 Fill to 4 with rf_ocupado=1 -> cheio=1, in_pronto=0, fifth offer not stored; release one pop plus offer same cycle -> offer rejected, contagem=3.
REQ-036 Steady stream 10 writes, rf_ocupado=0, one offer per cycle -> contagem stays 1, pointers wrap, all 10 reach register file in order.
REQ-037 Three entries pending, assert descarta with in_valido=1 -> next cycle contagem=0, vazio=1, offered write lost, fwd_*_valido=0.
REQ-038 Two entries pending, reset_n=0 for one edge -> contagem=0, reg_write=0, in_pronto=1 next cycle.
